mem_stage: RTL and testbench

Pipeline memory stage of the pipeline CPU, sitting between execute and writeback and directly driving the `mem` block's write/read ports. It accepts one execute-stage op per handshake: ALU pass-through, load or store. It turns loads and stores into RAM accesses, absorbs the RAM's one-cycle read latency, and presents a single registered result to writeback under a valid/ready handshake.

---
 rtl/mem_stage.sv | 158 +++++++++++++++
 tb/tb_mem_stage.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage between execute and writeback.
//
// Accepts one execute op per handshake (ALU pass-through, LOAD, STORE or
// bubble). Stores are written to the RAM on the accepting edge. Loads issue
// the RAM read on the accepting edge and capture the registered RAM output
// one edge later. The stage presents one registered result token to
// writeback under a valid/ready handshake.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ex_valid/ex_ready execute handshake (ex_ready is combinational)
//   ex_op             00 ALU, 01 LOAD, 10 STORE, 11 bubble
//   ex_addr/ex_wdata  load/store word address and store data
//   ex_alu/ex_rd      ALU result and destination register
//   wb_valid/wb_ready writeback handshake
//   wb_data/wb_rd/wb_we result token
//   mem_*             RAM write/read ports (mem_data_out is the RAM's
//                     registered read data)
//   retire_cnt        tokens consumed by writeback, wraps at 16 bits
module mem_stage #(
    parameter int DW = 16,
    parameter int AW = 7,
    parameter int RW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [1:0]    ex_op,
    input  logic [AW-1:0] ex_addr,
    input  logic [DW-1:0] ex_wdata,
    input  logic [DW-1:0] ex_alu,
    input  logic [RW-1:0] ex_rd,
    output logic          wb_valid,
    input  logic          wb_ready,
    output logic [DW-1:0] wb_data,
    output logic [RW-1:0] wb_rd,
    output logic          wb_we,
    output logic          mem_we,
    output logic [AW-1:0] mem_w_addr,
    output logic [AW-1:0] mem_r_addr,
    output logic [DW-1:0] mem_data_in,
    input  logic [DW-1:0] mem_data_out,
    output logic [15:0]   retire_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    localparam logic [1:0] OP_ALU   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_wb_valid;
    logic [DW-1:0] r_wb_data;
    logic [DW-1:0] w_wb_data_nxt;
    logic [RW-1:0] r_wb_rd;
    logic [RW-1:0] w_wb_rd_nxt;
    logic          r_wb_we;
    logic          w_wb_we_nxt;
    logic [15:0]   r_retire_cnt;

    logic          w_ready;
    logic          w_accept;
    logic          w_retire;

    // A new op may enter when the result register is empty, or when its
    // current token leaves this same cycle. A pending load blocks entry.
    assign w_ready  = !rst && ((r_state == S_IDLE) ||
                               ((r_state == S_FULL) && wb_ready));
    assign w_accept = ex_valid && w_ready;
    assign w_retire = (r_state == S_FULL) && wb_ready;

    assign ex_ready    = w_ready;
    assign mem_we      = w_accept && (ex_op == OP_STORE);
    assign mem_w_addr  = ex_addr;
    assign mem_r_addr  = ex_addr;
    assign mem_data_in = ex_wdata;

    assign wb_valid   = r_wb_valid;
    assign wb_data    = r_wb_data;
    assign wb_rd      = r_wb_rd;
    assign wb_we      = r_wb_we;
    assign retire_cnt = r_retire_cnt;

    always_comb begin
        w_state_nxt   = r_state;
        w_wb_data_nxt = r_wb_data;
        w_wb_rd_nxt   = r_wb_rd;
        w_wb_we_nxt   = r_wb_we;

        case (r_state)
            // RAM data for the load issued last edge is valid now.
            S_LOAD: begin
                w_wb_data_nxt = mem_data_out;
                w_state_nxt   = S_FULL;
            end
            S_FULL: begin
                if (wb_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: ;
        endcase

        // An accepted op overrides the drain above; it never occurs in LOAD.
        if (w_accept) begin
            w_wb_rd_nxt = ex_rd;
            case (ex_op)
                OP_ALU: begin
                    w_wb_data_nxt = ex_alu;
                    w_wb_we_nxt   = 1'b1;
                    w_state_nxt   = S_FULL;
                end
                OP_LOAD: begin
                    w_wb_we_nxt   = 1'b1;
                    w_state_nxt   = S_LOAD;
                end
                OP_STORE: begin
                    w_wb_data_nxt = ex_wdata;
                    w_wb_we_nxt   = 1'b0;
                    w_state_nxt   = S_FULL;
                end
                default: begin
                    w_wb_data_nxt = '0;
                    w_wb_we_nxt   = 1'b0;
                    w_state_nxt   = S_FULL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_wb_valid   <= 1'b0;
            r_wb_data    <= '0;
            r_wb_rd      <= '0;
            r_wb_we      <= 1'b0;
            r_retire_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_wb_valid <= (w_state_nxt == S_FULL);
            r_wb_data  <= w_wb_data_nxt;
            r_wb_rd    <= w_wb_rd_nxt;
            r_wb_we    <= w_wb_we_nxt;
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: behavioural RAM (registered read, read-before-write,
// initial contents 0x00FF) plus a transaction-level reference model of the
// expected result token, pending load and retire count.
module tb_mem_stage;
    localparam int DW = 16;
    localparam int AW = 7;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid;
    logic          ex_ready;
    logic [1:0]    ex_op;
    logic [AW-1:0] ex_addr;
    logic [DW-1:0] ex_wdata;
    logic [DW-1:0] ex_alu;
    logic [RW-1:0] ex_rd;
    logic          wb_valid;
    logic          wb_ready;
    logic [DW-1:0] wb_data;
    logic [RW-1:0] wb_rd;
    logic          wb_we;
    logic          mem_we;
    logic [AW-1:0] mem_w_addr;
    logic [AW-1:0] mem_r_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic [15:0]   retire_cnt;

    always #5 clk = ~clk;

    mem_stage #(.DW(DW), .AW(AW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_alu(ex_alu), .ex_rd(ex_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_we(wb_we),
        .mem_we(mem_we), .mem_w_addr(mem_w_addr), .mem_r_addr(mem_r_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .retire_cnt(retire_cnt)
    );

    // Environment RAM
    logic [DW-1:0] ram [0:127];
    always @(posedge clk) begin
        if (mem_we) ram[mem_w_addr] <= mem_data_in;
        mem_data_out <= ram[mem_r_addr];
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic          m_full, m_load, m_we, m_rdchk;
    logic [DW-1:0] m_data, m_ld_data;
    logic [RW-1:0] m_rd, m_ld_rd;
    logic [15:0]   m_cnt;
    logic [DW-1:0] ref_mem [0:127];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [DW-1:0] alu,
                         input logic [RW-1:0] rd, input logic rdy);
        ex_valid = v; ex_op = op; ex_addr = a; ex_wdata = wd;
        ex_alu = alu; ex_rd = rd; wb_ready = rdy;
    endtask

    // One clock: check everything mid-cycle, then advance the model at the edge.
    task automatic cycle();
        bit exp_ready, acc;
        @(negedge clk);
        exp_ready = !rst && !m_load && (!m_full || wb_ready);
        acc = exp_ready && ex_valid;
        chk("ex_ready", ex_ready, exp_ready);
        chk("mem_we", mem_we, acc && (ex_op == 2'b10));
        chk("mem_r_addr", mem_r_addr, ex_addr);
        chk("mem_w_addr", mem_w_addr, ex_addr);
        chk("mem_data_in", mem_data_in, ex_wdata);
        chk("wb_valid", wb_valid, m_full);
        chk("retire_cnt", retire_cnt, m_cnt);
        if (m_full) begin
            chk("wb_data", wb_data, m_data);
            chk("wb_we", wb_we, m_we);
            if (m_rdchk) chk("wb_rd", wb_rd, m_rd);
        end
        @(posedge clk);
        if (rst) begin
            m_full = 0; m_load = 0; m_cnt = 0;
        end else begin
            if (m_full && wb_ready) begin m_cnt = m_cnt + 16'd1; m_full = 0; end
            if (m_load) begin
                m_full = 1; m_data = m_ld_data; m_rd = m_ld_rd;
                m_we = 1; m_rdchk = 1; m_load = 0;
            end
            if (acc) begin
                case (ex_op)
                    2'b00: begin m_full = 1; m_data = ex_alu; m_rd = ex_rd; m_we = 1; m_rdchk = 1; end
                    2'b01: begin m_load = 1; m_ld_data = ref_mem[ex_addr]; m_ld_rd = ex_rd; end
                    2'b10: begin
                        ref_mem[ex_addr] = ex_wdata;
                        m_full = 1; m_data = ex_wdata; m_rd = ex_rd; m_we = 0; m_rdchk = 1;
                    end
                    default: begin m_full = 1; m_data = 16'h0000; m_we = 0; m_rdchk = 0; end
                endcase
            end
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            ram[i] = 16'h00FF;
            ref_mem[i] = 16'h00FF;
        end
        m_full = 0; m_load = 0; m_we = 0; m_rdchk = 0;
        m_data = 0; m_ld_data = 0; m_rd = 0; m_ld_rd = 0; m_cnt = 0;

        // Reset held with a STORE presented
        rst = 1'b1;
        drive(1, 2'b10, 7'h7F, 16'hDEAD, 16'h0, 3'd1, 1);
        @(posedge clk); #1;
        cycle();
        cycle();
        chk("rst_wb_data", wb_data, 16'h0000);
        chk("rst_wb_rd", wb_rd, 3'd0);
        chk("rst_wb_we", wb_we, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_retire", retire_cnt, 16'd0);
        rst = 1'b0;

        // Back-to-back ALU
        for (int i = 1; i <= 4; i++) begin
            drive(1, 2'b00, 7'h0, 16'h0, 16'h1111 * i[15:0], i[2:0], 1);
            cycle();
        end
        drive(0, 2'b00, 7'h0, 16'h0, 16'h0, 3'd0, 1);
        cycle();
        cycle();
        chk("alu_retire4", retire_cnt, 16'd4);

        // Store then load at 0x05, then load from 0x7F (written only under reset)
        drive(1, 2'b10, 7'h05, 16'hBEEF, 16'h0, 3'd2, 1);
        cycle();
        chk("st_token_we", wb_we, 1'b0);
        drive(1, 2'b01, 7'h05, 16'h0, 16'h0, 3'd3, 1);
        cycle();
        chk("ld_busy_ready", ex_ready, 1'b0);
        chk("ld_busy_valid", wb_valid, 1'b0);
        drive(1, 2'b01, 7'h7F, 16'h0, 16'h0, 3'd4, 1);
        cycle();
        chk("ld_beef", wb_data, 16'hBEEF);
        chk("ld_beef_we", wb_we, 1'b1);
        cycle();
        drive(0, 2'b00, 7'h0, 16'h0, 16'h0, 3'd0, 1);
        cycle();
        chk("ld_unwritten", wb_data, 16'h00FF);
        chk("ld_unwritten_rd", wb_rd, 3'd4);

        // Backpressure on token 0xA5A5
        drive(1, 2'b00, 7'h0, 16'h0, 16'hA5A5, 3'd5, 1);
        cycle();
        drive(1, 2'b00, 7'h0, 16'h0, 16'h5A5A, 3'd6, 0);
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_hold_data", wb_data, 16'hA5A5);
        chk("bp_hold_rd", wb_rd, 3'd5);
        wb_ready = 1'b1;
        cycle();
        chk("bp_replace", wb_data, 16'h5A5A);
        drive(0, 2'b00, 7'h0, 16'h0, 16'h0, 3'd0, 1);
        cycle();

        // Reset in the LOAD cycle
        drive(1, 2'b01, 7'h05, 16'h0, 16'h0, 3'd1, 1);
        cycle();
        rst = 1'b1; ex_valid = 1'b0;
        cycle();
        rst = 1'b0;
        chk("rstld_valid", wb_valid, 1'b0);
        cycle();
        chk("rstld_no_token", wb_valid, 1'b0);
        chk("rstld_no_retire", retire_cnt, 16'd0);
        drive(1, 2'b00, 7'h0, 16'h0, 16'h7777, 3'd7, 1);
        cycle();
        chk("post_rst_alu", wb_data, 16'h7777);
        chk("post_rst_valid", wb_valid, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 9) == 0) ? 7'h7F : 7'($urandom_range(0, 7));
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), a, 16'($urandom),
                  16'($urandom), 3'($urandom), 1'($urandom_range(0, 3) != 0));
            cycle();
        end

        // Retire counter wrap
        drive(0, 2'b00, 7'h0, 16'h0, 16'h0, 3'd0, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        drive(1, 2'b00, 7'h0, 16'h0, 16'h1234, 3'd2, 1);
        for (int i = 0; i < 70000 && m_cnt != 16'hFFFF; i++) cycle();
        chk("wrap_ffff", retire_cnt, 16'hFFFF);
        cycle();
        chk("wrap_zero", retire_cnt, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
